sync_filter: RTL and testbench

Parametrised multi-channel input conditioner: each channel passes an asynchronous input through a configurable-depth flip-flop synchroniser, then a stability (glitch/debounce) filter. Optional registered rise/fall pulses are provided per channel. Sits at the pin boundary in front of the UART receiver, buttons and other external level inputs. It replaces the fixed two-flop synchroniser where multiple lines, deeper metastability margin, a defined idle level or noise rejection is needed.

---
 rtl/sync_pkg.sv | 8 +
 rtl/sync_filter_ch.sv | 48 ++++
 rtl/sync_filter.sv | 33 +++
 tb/tb_sync_filter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// sync_pkg: shared defaults and counter sizing for the sync_filter input conditioner.
package sync_pkg;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int SYNC_FILTER_DEFAULT = 1;
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sync_filter_ch.sv
// sync_filter_ch: one channel of synchroniser chain, stability filter and edge pulses.
// Edge pulse registers exist only when SYNC_FILTER_EDGE_EN is defined.
module sync_filter_ch import sync_pkg::*; #(
    parameter int   STAGES        = SYNC_STAGES_DEFAULT,
    parameter int   FILTER_CYCLES = SYNC_FILTER_DEFAULT,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);
    logic [STAGES-1:0] chain;
    logic [CW-1:0]     cnt;
    logic              s;
    logic              done;
    assign s    = chain[STAGES-1];
    assign done = (s != o_stable) && (cnt == CNT_MAX);
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            chain    <= {STAGES{RESET_VAL}};
            o_stable <= RESET_VAL;
            cnt      <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], i_sig};
            cnt   <= (s == o_stable || done) ? '0 : cnt + CW'(1);
            if (done) o_stable <= s;
        end
    end
`ifdef SYNC_FILTER_EDGE_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            o_rise <= done & s;
            o_fall <= done & ~s;
        end
    end
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif
endmodule

// File: rtl/sync_filter.sv
// sync_filter: multi-channel synchroniser + debounce filter with optional edge pulses.
// Define SYNC_FILTER_EDGE_EN to build the o_rise/o_fall registers; otherwise they read 0.
module sync_filter import sync_pkg::*; #(
    parameter int                  CHANNELS      = 1,
    parameter int                  STAGES        = SYNC_STAGES_DEFAULT,
    parameter int                  FILTER_CYCLES = SYNC_FILTER_DEFAULT,
    parameter logic [CHANNELS-1:0] RESET_VAL     = {CHANNELS{1'b0}}
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHANNELS-1:0] i_sig,
    output logic [CHANNELS-1:0] o_stable,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall
);
    if (STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_param
        $fatal(1, "sync_filter: STAGES must be >= 2 and FILTER_CYCLES >= 1");
    end
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sync_filter_ch #(
            .STAGES        (STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_ch (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_sig    (i_sig[i]),
            .o_stable (o_stable[i]),
            .o_rise   (o_rise[i]),
            .o_fall   (o_fall[i])
        );
    end
endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: scoreboard bench over five sync_filter configurations sharing clock, reset and inputs.
module tb_sync_filter;
    typedef struct {int cyc; logic [3:0] val;} ev_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sig = '0;
    int         sel = 0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] rv = '0;
    logic [3:0] exp_lvl = '0;
    ev_t        exp_q[$];
    logic       s0, r0, f0, s1, r1, f1, s2, r2, f2, s4, r4, f4;
    logic [3:0] s3, r3, f3;
    logic [3:0] obs_s, obs_r, obs_f;

    always #5 clk = ~clk;

    sync_filter u_d0 (.i_clk(clk), .i_rst(rst), .i_sig(sig[0]), .o_stable(s0), .o_rise(r0), .o_fall(f0));
    sync_filter #(.STAGES(3), .FILTER_CYCLES(4), .RESET_VAL(1'b1)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_sig(sig[0]), .o_stable(s1), .o_rise(r1), .o_fall(f1));
    sync_filter #(.FILTER_CYCLES(4)) u_d2 (
        .i_clk(clk), .i_rst(rst), .i_sig(sig[0]), .o_stable(s2), .o_rise(r2), .o_fall(f2));
    sync_filter #(.CHANNELS(4)) u_d3 (
        .i_clk(clk), .i_rst(rst), .i_sig(sig), .o_stable(s3), .o_rise(r3), .o_fall(f3));
    sync_filter #(.FILTER_CYCLES(8)) u_d4 (
        .i_clk(clk), .i_rst(rst), .i_sig(sig[0]), .o_stable(s4), .o_rise(r4), .o_fall(f4));

    always_comb begin
        obs_s = {3'b0, s0};
        obs_r = {3'b0, r0};
        obs_f = {3'b0, f0};
        case (sel)
            1: begin obs_s = {3'b0, s1}; obs_r = {3'b0, r1}; obs_f = {3'b0, f1}; end
            2: begin obs_s = {3'b0, s2}; obs_r = {3'b0, r2}; obs_f = {3'b0, f2}; end
            3: begin obs_s = s3; obs_r = r3; obs_f = f3; end
            4: begin obs_s = {3'b0, s4}; obs_r = {3'b0, r4}; obs_f = {3'b0, f4}; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d edge=%0d got=%b expected=%b", tag, sel, cyc, obs, exp);
        end
    endtask

    // Advance one edge, retire due scoreboard events and compare all outputs.
    task automatic step();
        logic [3:0] nxt, er, ef;
        logic       was_rst;
        ev_t        e;
        was_rst = rst;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        nxt = exp_lvl;
        er  = '0;
        ef  = '0;
        if (was_rst) begin
            exp_q.delete();
            nxt = rv;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e   = exp_q.pop_front();
                nxt = e.val;
            end
`ifdef SYNC_FILTER_EDGE_EN
            er = nxt & ~exp_lvl;
            ef = exp_lvl & ~nxt;
`endif
        end
        check("stable", obs_s, nxt);
        check("rise", obs_r, er);
        check("fall", obs_f, ef);
        exp_lvl = nxt;
    endtask

    task automatic scn_start(input int s, input logic [3:0] r);
        sel     = s;
        rv      = r;
        sig     = r;
        rst     = 1'b1;
        cyc     = 0;
        exp_lvl = r;
        exp_q.delete();
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic push(input int c, input logic [3:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input int w, input bit pass, input int lat);
        int k;
        k   = cyc + 1;
        sig = 4'h1;
        if (pass) push(k + lat, 4'h1);
        repeat (w) step();
        sig = 4'h0;
        if (pass) push(k + w + lat, 4'h0);
        repeat (14) step();
    endtask

    initial begin
        // defaults: input high before edge 10 shows at edge 12
        scn_start(0, 4'h0);
        repeat (6) step();
        sig = 4'h1;
        push(12, 4'h1);
        repeat (8) step();
        // deep chain, long filter, idle-high: input low before edge 20 falls at edge 26
        scn_start(1, 4'h1);
        repeat (16) step();
        sig = 4'h0;
        push(26, 4'h0);
        repeat (10) step();
        // glitch rejection: 3-cycle pulses vanish, a 4-cycle pulse passes
        scn_start(2, 4'h0);
        pulse(3, 1'b0, 5);
        pulse(3, 1'b0, 5);
        pulse(4, 1'b1, 5);
        // parallel channels, including simultaneous rise and fall
        scn_start(3, 4'h0);
        repeat (2) step();
        sig = 4'b1010;
        push(cyc + 3, 4'b1010);
        repeat (5) step();
        sig = 4'b0101;
        push(cyc + 3, 4'b0101);
        repeat (5) step();
        // reset after five counts discards progress; full count needed afterwards
        scn_start(4, 4'h0);
        sig = 4'h1;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        push(cyc + 1 + 9, 4'h1);
        repeat (14) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
